// File: rtl/sram_ctrl_if.sv
// Request/response channel between cache control logic and one sram_ctrl instance.
// A beat transfers on a rising clk edge where valid && ready are both high.
// The sender holds valid and payload stable until then; ready may depend on the payload.
interface sram_ctrl_if #(
  parameter int DATA_W = 53,
  parameter int ADDR_W = 5
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_ctrl.sv
// Single-port SRAM initiator: zero-sweeps the array after reset/flush, then serves
// reads and writes, returning read data through a 2-entry in-order response buffer.
module sram_ctrl #(
  parameter int DATA_W = 53,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_req,
  output logic              init_done,
  sram_ctrl_if.slave        bus,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              dbg_state
);

  typedef enum logic {ST_INIT, ST_SERVE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              flush_pend_q, flush_pend_d;
  logic              rd_inflight_q, rd_inflight_d;
  logic [1:0]        count_q, count_d;
  logic              rd_ptr_q, wr_ptr_q;
  logic [DATA_W-1:0] buf_mem [2];

  logic       push, pop, credit_ok, accept;
  logic [2:0] occupancy;

  assign push = rd_inflight_q;
  assign pop  = bus.rsp_valid && bus.rsp_ready;

  // Reads already owed (buffered or in flight) must leave room for one more.
  assign occupancy = {1'b0, count_q} + {2'b00, rd_inflight_q} - {2'b00, pop};
  assign credit_ok = occupancy < 3'd2;

  assign bus.req_ready = (state_q == ST_SERVE) && !flush_req && !flush_pend_q &&
                         (bus.req_wen || credit_ok);
  assign accept        = bus.req_valid && bus.req_ready;

  assign bus.rsp_valid = (count_q != 2'd0);
  assign bus.rsp_rdata = bus.rsp_valid ? buf_mem[rd_ptr_q] : '0;
  assign init_done     = (state_q == ST_SERVE);
  assign dbg_state     = (state_q == ST_SERVE);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    flush_pend_d  = flush_pend_q;
    rd_inflight_d = 1'b0;
    sram_cen      = 1'b0;
    sram_wen      = 1'b0;
    sram_addr     = '0;
    sram_wdata    = '0;
    case (state_q)
      ST_INIT: begin
        sram_cen = 1'b1;
        sram_wen = 1'b1;
        sram_addr = cnt_q;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          cnt_d   = '0;
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (accept) begin
          sram_cen      = 1'b1;
          sram_wen      = bus.req_wen;
          sram_addr     = bus.req_addr;
          sram_wdata    = bus.req_wdata;
          rd_inflight_d = !bus.req_wen;
        end
        // The flush waits for an in-flight read so its data still lands in the buffer.
        if (flush_pend_q && !rd_inflight_q) begin
          state_d      = ST_INIT;
          cnt_d        = '0;
          flush_pend_d = 1'b0;
        end else if (flush_req) begin
          flush_pend_d = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
    if (rst) sram_cen = 1'b0;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_INIT;
      cnt_q         <= '0;
      flush_pend_q  <= 1'b0;
      rd_inflight_q <= 1'b0;
      count_q       <= 2'd0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      flush_pend_q  <= flush_pend_d;
      rd_inflight_q <= rd_inflight_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_q ^ pop;
      wr_ptr_q      <= wr_ptr_q ^ push;
    end
  end

  always_ff @(posedge clk) begin
    if (push) buf_mem[wr_ptr_q] <= sram_rdata;
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Initiator for the single-port SRAM macro port (cen/wen/addr/wdata/rdata, 1-cycle read latency, rdata zero when not reading).
- Sweeps every entry to zero after reset or on flush, so cache tag/data arrays start invalid.
- After the sweep, serves a valid/ready request channel.
- Returns read data through a 2-entry response buffer with backpressure. Sits between cache control logic and each sram instance.

Parameters:
- DATA_W, 53, SRAM word width.
- DEPTH, 32, number of SRAM entries.
- ADDR_W, $clog2(DEPTH), SRAM address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush_req  in  1  pulse: re-zero the whole array
- init_done  out  1  high when the array is initialised and requests are served
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_wen  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  read response valid
- rsp_ready  in  1  response consumer ready
- rsp_rdata  out  DATA_W  read response data
- sram_cen  out  1  SRAM chip enable
- sram_wen  out  1  SRAM write enable
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after a read enable

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=INIT, init counter=0, flush_pend=0, rd_inflight=0, response buffer emptied.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0.
  - While rst=1, sram_cen=0 (combinational override).
- Reset mid-operation: any in-flight read and any buffered responses are discarded. No response is ever emitted for them.
- States: INIT, SERVE.
- INIT:
  - Each cycle drives sram_cen=1, sram_wen=1, sram_addr=cnt, sram_wdata=0.
  - cnt increments each cycle.
  - After the cycle with cnt=DEPTH-1: cnt wraps to 0, state becomes SERVE, init_done=1 from the next cycle.
  - Sweep takes exactly DEPTH cycles.
  - req_ready=0 throughout; init_done=0 throughout.
- SERVE, SRAM outputs are combinational from the request:
  - sram_cen = req_valid && req_ready
  - sram_wen = req_wen
  - sram_addr = req_addr
  - sram_wdata = req_wdata
  - When no request is accepted: sram_cen=0, other SRAM outputs don't-care (drive 0).
- req_ready in SERVE:
  - Equals !flush_req && !flush_pend && (req_wen || credit_ok).
  - credit_ok = (buf_count + rd_inflight − pop) < 2, where pop = rsp_valid && rsp_ready.
  - Writes are never blocked by the response path.
- Write: committed at the accepting edge. Produces no response.
- Read accepted at edge of cycle t:
  - rd_inflight=1 during t+1.
  - sram_rdata is pushed into the buffer at end of t+1.
  - rsp_valid=1 in cycle t+2. Fixed read latency is 2 cycles.
- Back-to-back reads with rsp_ready=1 sustain 1 read/cycle.
- Response buffer: 2-entry FIFO, strict in-order.
  - rsp_rdata = head entry; rsp_rdata=0 when empty.
  - Simultaneous push and pop in the same cycle is legal; count is unchanged.
  - Overflow cannot occur by construction of credit_ok.
- Hazards:
  - Read in the cycle after a write to the same address returns the new data.
  - Write in the same cycle a read is in flight does not corrupt the in-flight read.
- Flush:
  - flush_req in SERVE sets flush_pend. req_ready drops in that same cycle.
  - When flush_pend=1 and rd_inflight=0: state becomes INIT, cnt=0, init_done=0, flush_pend cleared.
  - Buffered responses remain and keep draining normally during INIT.
  - flush_req during INIT is ignored.
  - flush_req in the same cycle as req_valid: flush wins, the request is not accepted.
- Response signals are never affected by req_* in the same cycle; no combinational path from req_* to rsp_*.

Test Plan:
- Release rst -> sram_cen=1, wen=1, addr 0..31, wdata=0 over 32 consecutive cycles; init_done and req_ready rise on cycle 33; no cen afterwards while req_valid=0.
- Write addr 5 = 53'h1_2345_6789, then read addr 5 the next cycle -> rsp_valid exactly 2 cycles after read accept, rsp_rdata=53'h1_2345_6789, then rsp_valid=0.
- 8 back-to-back reads of addrs 0..7 (preloaded with value=addr+100) with rsp_ready=1 -> req_ready stays 1, 8 consecutive responses 100..107 in order.
- rsp_ready=0 while streaming reads -> exactly 2 reads accepted, then req_ready=0 for reads while writes are still accepted; raise rsp_ready -> both responses delivered in order, no loss or duplication.
- Write nonzero to addrs 3 and 31, pulse flush_req concurrent with req_valid -> request not accepted, 32-cycle zero sweep, init_done returns, reads of 3 and 31 return 0.
- Assert rst 1 cycle after a read accept -> rsp_valid=0 next cycle, no response ever appears for that read, INIT sweep restarts from addr 0.
